// File: rtl/chr_watch_pkg.sv
// rtl/chr_watch_pkg.sv - shared constants for the CHR bus event front-end
package chr_watch_pkg;

  localparam logic [13:0] CHR_LATCH_MASK = 14'h2FF8;
  localparam logic [13:0] CHR_LATCH_FD   = 14'h0FD8;
  localparam logic [13:0] CHR_LATCH_FE   = 14'h0FE8;
  localparam int          LOW_M2_MIN_DEF = 3;

endpackage

// File: rtl/chr_a12_watch_sat_counter.sv
// rtl/chr_a12_watch_sat_counter.sv - saturating up-counter with set/clear priority
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         set,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  // set beats clear beats increment
  always_comb begin
    cnt_d = cnt_q;
    if (set)
      cnt_d = MAX;
    else if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != MAX))
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/chr_a12_watch.sv
// rtl/chr_a12_watch.sv - turns the PPU CHR bus into filtered A12-rise, read and latch-hit pulses
module chr_a12_watch
  import chr_watch_pkg::*;
#(
  parameter int LOW_M2_MIN = LOW_M2_MIN_DEF,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        ce,
  input  logic        ppu_ce,
  input  logic [13:0] chr_ain,
  input  logic        chr_read,
  output logic        a12_rise,
  output logic        a12_level,
  output logic        rd_strobe,
  output logic        latch_hit0,
  output logic        latch_hit1,
  output logic        latch_side,
  output logic [7:0]  rise_count
);

  localparam logic [CNT_W-1:0] LOW_MIN = CNT_W'(LOW_M2_MIN);

  logic             prev_a12_q, prev_a12_d;
  logic             a12_rise_q, a12_rise_d;
  logic             rd_strobe_q, rd_strobe_d;
  logic             latch_hit0_q, latch_hit0_d;
  logic             latch_hit1_q, latch_hit1_d;
  logic             latch_side_q, latch_side_d;
  logic [7:0]       rise_count_q, rise_count_d;
  logic [CNT_W-1:0] low_cnt;

  logic a12_now, rise_ok, rd_ev, fd_hit, fe_hit;

  assign a12_now = chr_ain[12];
  // low_cnt here is the pre-update value, so a coincident ce cannot help a rise pass
  assign rise_ok = ppu_ce && a12_now && !prev_a12_q && (low_cnt >= LOW_MIN);
  assign rd_ev   = ppu_ce && chr_read;
  assign fd_hit  = rd_ev && ((chr_ain & CHR_LATCH_MASK) == CHR_LATCH_FD);
  assign fe_hit  = rd_ev && ((chr_ain & CHR_LATCH_MASK) == CHR_LATCH_FE);

  // disabled: counter parks saturated so the first rise after enable is accepted
  sat_counter #(.W(CNT_W)) u_low_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .set     (!enable),
    .clr     (enable && ppu_ce && a12_now),
    .inc     (enable && ce && !prev_a12_q),
    .cnt     (low_cnt)
  );

  always_comb begin
    prev_a12_d   = prev_a12_q;
    rise_count_d = rise_count_q;
    latch_side_d = latch_side_q;
    a12_rise_d   = 1'b0;
    rd_strobe_d  = 1'b0;
    latch_hit0_d = 1'b0;
    latch_hit1_d = 1'b0;
    if (!enable) begin
      prev_a12_d   = 1'b0;
      rise_count_d = 8'd0;
      latch_side_d = 1'b0;
    end else begin
      if (ppu_ce)
        prev_a12_d = a12_now;
      a12_rise_d = rise_ok;
      if (rise_ok)
        rise_count_d = rise_count_q + 8'd1;
      rd_strobe_d  = rd_ev;
      latch_hit0_d = fd_hit;
      latch_hit1_d = fe_hit;
      if (fd_hit || fe_hit)
        latch_side_d = a12_now;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_a12_q   <= 1'b0;
      a12_rise_q   <= 1'b0;
      rd_strobe_q  <= 1'b0;
      latch_hit0_q <= 1'b0;
      latch_hit1_q <= 1'b0;
      latch_side_q <= 1'b0;
      rise_count_q <= 8'd0;
    end else begin
      prev_a12_q   <= prev_a12_d;
      a12_rise_q   <= a12_rise_d;
      rd_strobe_q  <= rd_strobe_d;
      latch_hit0_q <= latch_hit0_d;
      latch_hit1_q <= latch_hit1_d;
      latch_side_q <= latch_side_d;
      rise_count_q <= rise_count_d;
    end
  end

  assign a12_rise   = a12_rise_q;
  assign a12_level  = prev_a12_q;
  assign rd_strobe  = rd_strobe_q;
  assign latch_hit0 = latch_hit0_q;
  assign latch_hit1 = latch_hit1_q;
  assign latch_side = latch_side_q;
  assign rise_count = rise_count_q;

endmodule
